// File: rtl/bmm_pkg.sv
// Shared types for the zero-run-length decoder: FSM state and token record.
package bmm_pkg;

  typedef enum logic {
    FILL,
    HOLD
  } zrl_state_e;

  // Token counts are carried at a fixed maximum width and narrowed per instance.
  localparam int ZRL_CNT_MAX_W = 16;

  typedef struct packed {
    logic [ZRL_CNT_MAX_W-1:0] cnt;
    logic                     empty;
  } zrl_tok_t;

endpackage

// File: rtl/zrl_onehot.sv
// Combinational index-to-one-hot decode; MODE=0 maps index to bit idx, MODE=1 to bit WIDTH-1-idx.
module zrl_onehot #(
  parameter int WIDTH = 8,
  parameter bit MODE  = 1'b0,
  parameter int IDX_W = (WIDTH == 1 ? 1 : $clog2(WIDTH))
) (
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      onehot[i] = (idx == IDX_W'(MODE ? (WIDTH - 1 - i) : i));
    end
  end

endmodule

// File: rtl/zrl_decoder.sv
// Zero-run-length decoder: rebuilds a WIDTH-bit vector from (zero-count, empty) tokens.
// Optional saturating overflow counter on err_cnt_o when BMM_ZRLD_ERR_CNT_EN is defined.
module zrl_decoder
  import bmm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MODE      = 1'b0,
  parameter int CNT_WIDTH = (WIDTH == 1 ? 1 : $clog2(WIDTH))
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tok_valid_i,
  output logic                 tok_ready_o,
  input  logic [CNT_WIDTH-1:0] tok_cnt_i,
  input  logic                 tok_empty_i,
  output logic [WIDTH-1:0]     vec_o,
  output logic                 vec_valid_o,
  input  logic                 vec_ready_i,
  output logic                 err_o
`ifdef BMM_ZRLD_ERR_CNT_EN
  ,
  output logic [15:0]          err_cnt_o
`endif
);

  localparam logic [CNT_WIDTH+1:0] LAST = (CNT_WIDTH + 2)'(WIDTH - 1);

  zrl_state_e             state, state_n;
  zrl_tok_t               tok;
  logic [CNT_WIDTH:0]     pos;
  logic [CNT_WIDTH+1:0]   sum;
  logic [WIDTH-1:0]       vec, bit_hot;
  logic                   err;
  logic                   accept, ovf, hit;

  assign tok.cnt   = ZRL_CNT_MAX_W'(tok_cnt_i);
  assign tok.empty = tok_empty_i;

  // Upper count bits are zero-extended, so narrowing here is lossless.
  assign sum    = (CNT_WIDTH + 2)'(pos) + (CNT_WIDTH + 2)'(tok.cnt);
  assign accept = tok_valid_i && (state == FILL);
  assign ovf    = accept && !tok.empty && (sum > LAST);
  assign hit    = accept && !tok.empty && (sum <= LAST);

  zrl_onehot #(
    .WIDTH (WIDTH),
    .MODE  (MODE),
    .IDX_W (CNT_WIDTH)
  ) u_onehot (
    .idx    (sum[CNT_WIDTH-1:0]),
    .onehot (bit_hot)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= FILL;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FILL: if (accept && (tok.empty || sum >= LAST)) state_n = HOLD;
      HOLD: if (vec_ready_i) state_n = FILL;
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vec <= '0;
      pos <= '0;
      err <= 1'b0;
    end else if (state == HOLD) begin
      if (vec_ready_i) begin
        vec <= '0;
        pos <= '0;
        err <= 1'b0;
      end
    end else if (hit) begin
      vec <= vec | bit_hot;
      pos <= (CNT_WIDTH + 1)'(sum + 1'b1);
    end else if (ovf) begin
      err <= 1'b1;
    end
  end

`ifdef BMM_ZRLD_ERR_CNT_EN
  logic [15:0] err_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      err_cnt <= '0;
    else if (ovf && err_cnt != '1)    err_cnt <= err_cnt + 16'd1;
  end

  assign err_cnt_o = err_cnt;
`endif

  assign tok_ready_o = (state == FILL);
  assign vec_valid_o = (state == HOLD);
  assign vec_o       = vec;
  assign err_o       = err;

endmodule

// File: tb/tb_zrl_decoder.sv
// Bench for zrl_decoder: MODE=0 and MODE=1 instances share stimulus and are checked
// every cycle against a position/bit-list model; directed vectors pin the model too.
module tb_zrl_decoder;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tok_valid = 1'b0;
  logic [CW-1:0] tok_cnt = '0;
  logic          tok_empty = 1'b0;
  logic          vec_ready = 1'b0;

  logic          rdy0, rdy1, val0, val1, err0, err1;
  logic [W-1:0]  vec0, vec1;
`ifdef BMM_ZRLD_ERR_CNT_EN
  logic [15:0]   ecnt0, ecnt1;
`endif

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  zrl_decoder #(.WIDTH(W), .MODE(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .tok_valid_i(tok_valid), .tok_ready_o(rdy0),
    .tok_cnt_i(tok_cnt), .tok_empty_i(tok_empty), .vec_o(vec0),
    .vec_valid_o(val0), .vec_ready_i(vec_ready), .err_o(err0)
`ifdef BMM_ZRLD_ERR_CNT_EN
    , .err_cnt_o(ecnt0)
`endif
  );

  zrl_decoder #(.WIDTH(W), .MODE(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .tok_valid_i(tok_valid), .tok_ready_o(rdy1),
    .tok_cnt_i(tok_cnt), .tok_empty_i(tok_empty), .vec_o(vec1),
    .vec_valid_o(val1), .vec_ready_i(vec_ready), .err_o(err1)
`ifdef BMM_ZRLD_ERR_CNT_EN
    , .err_cnt_o(ecnt1)
`endif
  );

  // Model: "closed" flag, next free position and the set of written bit indices.
  bit           m_closed;
  int           m_pos;
  logic [W-1:0] m_vec0, m_vec1;
  bit           m_err;
  int           m_ecnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_closed = 0; m_pos = 0; m_vec0 = '0; m_vec1 = '0; m_err = 0; m_ecnt = 0;
    end else if (!m_closed) begin
      if (tok_valid) begin
        if (tok_empty) begin
          m_closed = 1;
        end else if (m_pos + int'(tok_cnt) < W) begin
          int s;
          s = m_pos + int'(tok_cnt);
          m_vec0[s] = 1'b1;
          m_vec1[W-1-s] = 1'b1;
          m_pos = s + 1;
          if (m_pos == W) m_closed = 1;
        end else begin
          m_err = 1;
          m_closed = 1;
          if (m_ecnt < 65535) m_ecnt++;
        end
      end
    end else if (vec_ready) begin
      m_closed = 0; m_pos = 0; m_vec0 = '0; m_vec1 = '0; m_err = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_ready0", 32'(rdy0), 32'(!m_closed));
      chk("cyc_ready1", 32'(rdy1), 32'(!m_closed));
      chk("cyc_valid0", 32'(val0), 32'(m_closed));
      chk("cyc_valid1", 32'(val1), 32'(m_closed));
      chk("cyc_vec0", 32'(vec0), 32'(m_vec0));
      chk("cyc_vec1", 32'(vec1), 32'(m_vec1));
      chk("cyc_err0", 32'(err0), 32'(m_err));
      chk("cyc_err1", 32'(err1), 32'(m_err));
`ifdef BMM_ZRLD_ERR_CNT_EN
      chk("cyc_ecnt0", 32'(ecnt0), 32'(m_ecnt));
      chk("cyc_ecnt1", 32'(ecnt1), 32'(m_ecnt));
`endif
    end
  end

  // Offer one token and return #1 after the edge that accepted it.
  task automatic send(input int cnt, input bit empty);
    bit done = 0;
    @(negedge clk);
    tok_cnt = CW'(cnt);
    tok_empty = empty;
    tok_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rdy0) begin
        @(posedge clk); #1;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    tok_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic release_vec();
    @(negedge clk);
    vec_ready = 1'b1;
    @(posedge clk); #1;
    vec_ready = 1'b0;
    chk("release_ready", 32'(rdy0), 32'd1);
    chk("release_vec", 32'(vec0), 32'd0);
  endtask

  task automatic expect_close(input string name, input logic [7:0] v0, input logic [7:0] v1,
                              input bit e);
    chk({name, "_valid"}, 32'(val0), 32'd1);
    chk({name, "_vec0"}, 32'(vec0), 32'(v0));
    chk({name, "_vec1"}, 32'(vec1), 32'(v1));
    chk({name, "_err"}, 32'(err0), 32'(e));
    chk({name, "_model0"}, 32'(m_vec0), 32'(v0));
    chk({name, "_model1"}, 32'(m_vec1), 32'(v1));
  endtask

  initial begin
    #3;
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_valid", 32'(val0), 32'd0);
    chk("rst_vec", 32'(vec0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    #9 rst_n = 1'b1;

    // Overflow close: bit 5 set, then 6+5 runs past the end.
    send(5, 0);
    chk("ovf_open", 32'(val0), 32'd0);
    send(5, 0);
    expect_close("ovf", 8'h20, 8'h04, 1'b1);
`ifdef BMM_ZRLD_ERR_CNT_EN
    chk("ovf_ecnt", 32'(ecnt0), 32'd1);
`endif
    release_vec();

    send(3, 0);
    send(0, 0);
    chk("lat_before", 32'(val0), 32'd0);
    send($urandom_range(0, 7), 1);
    expect_close("basic", 8'h18, 8'h18, 1'b0);
    release_vec();

    send(0, 0);
    send(2, 1);
    expect_close("empty", 8'h01, 8'h80, 1'b0);
    release_vec();

    send(7, 0);
    expect_close("auto", 8'h80, 8'h01, 1'b0);

    // Backpressure: stay in HOLD with a token offered for 3 cycles.
    tok_valid = 1'b1; tok_cnt = '0; tok_empty = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_vec", 32'(vec0), 32'h80);
      chk("bp_err", 32'(err0), 32'd0);
      chk("bp_ready", 32'(rdy0), 32'd0);
      chk("bp_valid", 32'(val0), 32'd1);
    end
    tok_valid = 1'b0;
    release_vec();

    // Mid-vector asynchronous reset discards the partial vector.
    send(2, 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_vec0", 32'(vec0), 32'd0);
    chk("arst_vec1", 32'(vec1), 32'd0);
    chk("arst_ready", 32'(rdy0), 32'd1);
    chk("arst_valid", 32'(val0), 32'd0);
    chk("arst_err", 32'(err0), 32'd0);
    #1 rst_n = 1'b1;
    send(1, 1);
    expect_close("post_rst", 8'h00, 8'h00, 1'b0);
    release_vec();

    // Randomised traffic; model and per-cycle compare do the checking.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      tok_valid = ($urandom_range(0, 1) == 1);
      tok_cnt   = CW'($urandom_range(0, 7));
      tok_empty = ($urandom_range(0, 7) == 0);
      vec_ready = ($urandom_range(0, 2) != 0);
    end
    tok_valid = 1'b0;
    vec_ready = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/zrl_decoder.md
ZRL_DECODER -- requirements
Module: zrl_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: output vector width, >= 1.
REQ-002 SHALL have parameter MODE, default 1'b0: 0 fills from LSB (trailing-zero order), 1 fills from MSB (leading-zero order).
REQ-003 SHALL have parameter CNT_WIDTH, default (WIDTH == 1 ? 1 : $clog2(WIDTH)): dependent, never overridden.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state rises on its posedge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port tok_valid_i, input, 1 bit: token offered.
REQ-007 SHALL have port tok_ready_o, output, 1 bit: token accepted when tok_valid_i and tok_ready_o are both high.
REQ-008 SHALL have port tok_cnt_i, input, CNT_WIDTH bits: zeros preceding the next one-bit.
REQ-009 SHALL have port tok_empty_i, input, 1 bit: no further one-bit; pad the rest with zeros and close the vector.
REQ-010 SHALL have port vec_o, output, WIDTH bits: reconstructed vector.
REQ-011 SHALL have port vec_valid_o / vec_ready_i, output / input, 1 bit each: output handshake.
REQ-012 SHALL have port err_o, output, 1 bit: asserted with vec_valid_o when the vector closed on overflow.

Function
REQ-013 SHALL implement FSM {FILL, HOLD}; tok_ready_o = (state == FILL), vec_valid_o = (state == HOLD), both driven from registers only.
REQ-014 SHALL keep position pos of CNT_WIDTH+1 bits and compute sum = pos + tok_cnt_i at CNT_WIDTH+2 bits, never truncating.
REQ-015 SHALL on accepted token with tok_empty_i=1 ignore tok_cnt_i, leave the vector unchanged and go to HOLD.
REQ-016 SHALL on accepted token with tok_empty_i=0 and sum <= WIDTH-1 set bit sum (MODE=0) or bit WIDTH-1-sum (MODE=1), load pos = sum+1, and go to HOLD iff sum+1 == WIDTH.
REQ-017 SHALL on accepted token with tok_empty_i=0 and sum > WIDTH-1 leave the vector unchanged, set the error flag and go to HOLD.
REQ-018 SHALL present vec_valid_o in the cycle after the closing token is accepted (latency 1), with vec_o and err_o stable while vec_ready_i is low.
REQ-019 SHALL on vec_ready_i high in HOLD clear the vector, pos and the error flag and return to FILL next cycle; there is no HOLD-to-FILL bypass.
REQ-020 SHALL ignore tok_* while in HOLD and vec_ready_i while in FILL.

Reset
REQ-021 SHALL on rst_ni low, immediately and independent of clk_i, set state=FILL, pos=0, vec_o='0, err_o=0, vec_valid_o=0, tok_ready_o=1, including when asserted mid-vector (the partial vector is discarded).

Configuration
REQ-022 SHALL with BMM_ZRLD_ERR_CNT_EN defined add output err_cnt_o [15:0], reset 0, incremented on each overflow close (REQ-017) and saturating at 16'hFFFF.
REQ-023 SHALL without BMM_ZRLD_ERR_CNT_EN omit err_cnt_o and its counter entirely.

Structure
REQ-024 SHALL take the FSM state enum and the zrl token struct {cnt, empty} from the shared package bmm_pkg.
REQ-025 SHALL place the MODE-aware index-to-one-hot decode in sub-module zrl_onehot (combinational, WIDTH/MODE parameters); the sequential logic stays in zrl_decoder.

Verification (WIDTH=8 unless stated)
REQ-026 SHALL test: MODE=0, tokens (3,0),(0,0),(x,1) -> vec_o=8'h18, err_o=0, valid one cycle after third acceptance.
REQ-027 SHALL test: MODE=0 tokens (0,0),(2,1) -> 8'h01; MODE=1 same tokens -> 8'h80.
REQ-028 SHALL test: MODE=0 token (7,0) -> auto-close, vec_o=8'h80, err_o=0, without an empty token.
REQ-029 SHALL test: MODE=0 tokens (5,0),(5,0) -> vec_o=8'h20, err_o=1; with BMM_ZRLD_ERR_CNT_EN, err_cnt_o=1.
REQ-030 SHALL test: vec_ready_i held low 3 cycles in HOLD -> vec_o/err_o stable, tok_ready_o=0, tokens offered not consumed.
REQ-031 SHALL test: rst_ni pulsed low after token (2,0) -> all outputs at reset values asynchronously; then (1,1) -> vec_o=8'h00.
